// File: rtl/uart_line_framer.sv
// uart_line_framer: buffers bytes from the uart receive stream until an
// end-of-line byte arrives, then replays the line as an AXI-Stream packet
// with tlast on the final byte. Lines that are too long are dropped whole
// and counted.
module uart_line_framer #(
    parameter int         MAX_LEN  = 64,
    parameter logic [7:0] EOL_CHAR = 8'h0A,
    parameter bit         DROP_CR  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  len_q, len_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic           s_rdy_q, s_rdy_d;
    logic           m_valid_q, m_valid_d;
    logic [7:0]     m_data_q, m_data_d;
    logic           m_last_q, m_last_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    drop_q, drop_d;

    logic [7:0]     line_mem [MAX_LEN];
    logic           wr_en_s;
    logic [AW-1:0]  wr_addr_s;
    logic [7:0]     wr_data_s;
    logic           in_acc_s;
    logic           out_acc_s;
    logic [CW-1:0]  nidx_s;

    // Next-state, buffer write and output-register computation.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        idx_d     = idx_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        ovf_d     = 1'b0;
        drop_d    = drop_q;
        wr_en_s   = 1'b0;
        wr_addr_s = count_q[AW-1:0];
        wr_data_s = s_axis_tdata;
        in_acc_s  = s_axis_tvalid && s_rdy_q;
        out_acc_s = m_valid_q && m_axis_tready;
        nidx_s    = idx_q + CW'(1);

        case (state_q)
            ST_FILL: begin
                if (in_acc_s) begin
                    if (DROP_CR && (s_axis_tdata == 8'h0D)) begin
                        state_d = ST_FILL;
                    end else if (s_axis_tdata == EOL_CHAR) begin
                        if (count_q == '0) begin
                            state_d = ST_FILL;
                        end else begin
                            // First beat is presented the cycle after EOL.
                            len_d     = count_q;
                            idx_d     = '0;
                            m_valid_d = 1'b1;
                            m_data_d  = line_mem[0];
                            m_last_d  = (count_q == CW'(1));
                            state_d   = ST_DRAIN;
                        end
                    end else if (count_q < CW'(MAX_LEN)) begin
                        wr_en_s = 1'b1;
                        count_d = count_q + CW'(1);
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (out_acc_s) begin
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        m_data_d  = 8'h00;
                        count_d   = '0;
                        state_d   = ST_FILL;
                    end else begin
                        idx_d    = nidx_s;
                        m_data_d = line_mem[nidx_s[AW-1:0]];
                        m_last_d = (nidx_s == (len_q - CW'(1)));
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DISCARD: begin
                if (in_acc_s && (s_axis_tdata == EOL_CHAR)) begin
                    ovf_d   = 1'b1;
                    drop_d  = (drop_q == 16'hFFFF) ? drop_q : (drop_q + 16'd1);
                    count_d = '0;
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d   = ST_FILL;
                count_d   = '0;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                m_data_d  = 8'h00;
            end
        endcase

        s_rdy_d = (state_d != ST_DRAIN);
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            count_q   <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            s_rdy_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
            ovf_q     <= 1'b0;
            drop_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            s_rdy_q   <= s_rdy_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    // Line buffer storage; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            line_mem[wr_addr_s] <= wr_data_s;
        end
    end

    assign s_axis_tready = s_rdy_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign overflow      = ovf_q;
    assign drop_count    = drop_q;

endmodule
